// File: rtl/mem_arr_pingpong_if.sv
// Handshake/bus bundle for the ping/pong row buffer: a loader/sequencer side
// (master) and the buffer itself (slave).
interface mem_arr_pingpong_if #(
  parameter int SYS_ROW    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 8
);
  logic [SYS_ROW-1:0]                 wr_en;
  logic [SYS_ROW-1:0][ADDR_W-1:0]     wr_addr;
  logic [SYS_ROW-1:0][DATA_WIDTH-1:0] wr_data;
  logic                               wr_ready;
  logic                               wr_commit;
  logic                               rd_start;
  logic [ADDR_W:0]                    rd_len;
  logic                               rd_busy;
  logic [SYS_ROW-1:0]                 rd_valid;
  logic [SYS_ROW-1:0][DATA_WIDTH-1:0] rd_data;
  logic                               rd_done;
  logic [1:0]                         full;

  modport master (
    output wr_en, wr_addr, wr_data, wr_commit, rd_start, rd_len,
    input  wr_ready, rd_busy, rd_valid, rd_data, rd_done, full
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_commit, rd_start, rd_len,
    output wr_ready, rd_busy, rd_valid, rd_data, rd_done, full
  );
endinterface

// File: rtl/mem_arr_pingpong.sv
// Double-buffered per-row operand buffer for the systolic array. The loader
// fills one half of every row bank while the sequencer streams the other
// half, optionally skewing row r by r cycles so operands arrive as a wavefront.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for rd_start on a full read half
// S_RUN   | issuing word addresses 0..len-1 into the skew pipe
// S_DRAIN | waiting for the last row to emit word len-1; then rd_done
module mem_arr_pingpong #(
  parameter int SYS_ROW    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int SKEW_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_arr_pingpong_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // One stage per row when skewed; a single shared stage when aligned.
  localparam int              NSTG    = (SKEW_EN != 0) ? SYS_ROW : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [1:0]              state, state_nxt;
  logic [1:0]              full;
  logic                    wr_sel, rd_sel;
  logic [ADDR_W-1:0]       k, len_m1;
  logic                    wr_ok, commit_ok, start_ok, issue, done, last_q;
  logic [NSTG-1:0]         stg_en, stg_last;
  logic [NSTG-1:0][ADDR_W-1:0] stg_addr;
  logic [SYS_ROW-1:0]      val_q;

  assign wr_ok     = !full[wr_sel];
  assign commit_ok = bus.wr_commit && wr_ok;
  assign start_ok  = (state == S_IDLE) && bus.rd_start && full[rd_sel] && (bus.rd_len != '0);
  assign issue     = (state == S_RUN);
  assign done      = (state == S_DRAIN) && last_q;

  assign bus.wr_ready = wr_ok;
  assign bus.rd_busy  = (state != S_IDLE);
  assign bus.rd_valid = val_q;
  assign bus.rd_done  = done;
  assign bus.full     = full;

  // Next-state logic for the read sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_RUN;
      S_RUN:   if (k == len_m1) state_nxt = S_DRAIN;
      S_DRAIN: if (last_q) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state, latched length and word address counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      k      <= '0;
      len_m1 <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        k <= '0;
        // rd_len == DEPTH has all-zero low bits, so the wrap gives DEPTH-1.
        len_m1 <= (bus.rd_len > DEPTH_L) ? ADDR_W'(DEPTH - 1)
                                         : bus.rd_len[ADDR_W-1:0] - ADDR_W'(1);
      end else if (issue && (k != len_m1)) begin
        k <= k + ADDR_W'(1);
      end
    end
  end

  // Half ownership: commit hands the fill half over, done frees the read half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      if (commit_ok) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end
      if (done) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
    end
  end

  // Skew chain ahead of the banks: stage r feeds row r's read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_en   <= '0;
      stg_last <= '0;
      stg_addr <= '0;
    end else begin
      stg_en[0]   <= issue;
      stg_last[0] <= issue && (k == len_m1);
      stg_addr[0] <= k;
      for (int i = 1; i < NSTG; i++) begin
        stg_en[i]   <= stg_en[i-1];
        stg_last[i] <= stg_last[i-1];
        stg_addr[i] <= stg_addr[i-1];
      end
    end
  end

  // Output valids track the bank reads; last_q marks the final row's last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q  <= '0;
      last_q <= 1'b0;
    end else begin
      for (int r = 0; r < SYS_ROW; r++) begin
        val_q[r] <= stg_en[(SKEW_EN != 0) ? r : 0];
      end
      last_q <= stg_last[NSTG-1];
    end
  end

  for (genvar r = 0; r < SYS_ROW; r++) begin : g_row
    localparam int SRC = (SKEW_EN != 0) ? r : 0;
    logic [DATA_WIDTH-1:0] mem [2*DEPTH];
    logic [DATA_WIDTH-1:0] raw;

    // 1R1W bank: writer owns half wr_sel, reader owns half rd_sel.
    always_ff @(posedge clk) begin
      if (bus.wr_en[r] && wr_ok) mem[{wr_sel, bus.wr_addr[r]}] <= bus.wr_data[r];
      if (stg_en[SRC]) raw <= mem[{rd_sel, stg_addr[SRC]}];
    end

    assign bus.rd_data[r] = val_q[r] ? raw : '0;
  end

endmodule

// File: tb/tb_mem_arr_pingpong.sv
// Bench for mem_arr_pingpong: a skewed and an aligned instance share one
// stimulus stream; a timeline model predicts every output each cycle.
module tb_mem_arr_pingpong;
  localparam int R = 4, DW = 16, DEPTH = 256, AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [R-1:0]         wr_en;
  logic [R-1:0][AW-1:0] wr_addr;
  logic [R-1:0][DW-1:0] wr_data;
  logic                 wr_commit, rd_start;
  logic [AW:0]          rd_len;

  mem_arr_pingpong_if #(.SYS_ROW(R), .DATA_WIDTH(DW), .ADDR_W(AW)) bus_s ();
  mem_arr_pingpong_if #(.SYS_ROW(R), .DATA_WIDTH(DW), .ADDR_W(AW)) bus_a ();

  assign bus_s.wr_en = wr_en;     assign bus_a.wr_en = wr_en;
  assign bus_s.wr_addr = wr_addr; assign bus_a.wr_addr = wr_addr;
  assign bus_s.wr_data = wr_data; assign bus_a.wr_data = wr_data;
  assign bus_s.wr_commit = wr_commit; assign bus_a.wr_commit = wr_commit;
  assign bus_s.rd_start = rd_start;   assign bus_a.rd_start = rd_start;
  assign bus_s.rd_len = rd_len;       assign bus_a.rd_len = rd_len;

  mem_arr_pingpong #(.SYS_ROW(R), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SKEW_EN(1))
    dut_s (.clk(clk), .rst(rst), .bus(bus_s));
  mem_arr_pingpong #(.SYS_ROW(R), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SKEW_EN(0))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  // index 0 = skewed instance, 1 = aligned instance
  logic [1:0]         o_ready, o_busy, o_done;
  logic [R-1:0]       o_valid [2];
  logic [R-1:0][DW-1:0] o_data [2];
  logic [1:0]         o_full [2];
  assign o_ready[0] = bus_s.wr_ready; assign o_ready[1] = bus_a.wr_ready;
  assign o_busy[0]  = bus_s.rd_busy;  assign o_busy[1]  = bus_a.rd_busy;
  assign o_done[0]  = bus_s.rd_done;  assign o_done[1]  = bus_a.rd_done;
  assign o_valid[0] = bus_s.rd_valid; assign o_valid[1] = bus_a.rd_valid;
  assign o_data[0]  = bus_s.rd_data;  assign o_data[1]  = bus_a.rd_data;
  assign o_full[0]  = bus_s.full;     assign o_full[1]  = bus_a.full;

  int errors = 0, checks = 0;
  int cyc = 0;

  task automatic chk(string name, int m, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, m, act, exp, cyc);
    end
  endtask

  // Model: contents per half, half ownership, and the active run's timeline.
  logic [DW-1:0] mm [2][2][R][DEPTH];
  logic [1:0] m_full [2];
  bit m_wsel [2], m_rsel [2], m_busy [2], m_half [2];
  int m_t0 [2], m_len [2], m_dcyc [2];

  always @(posedge clk or posedge rst) begin
    bit st, dn;
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        m_full[m] = 2'b00; m_wsel[m] = 0; m_rsel[m] = 0; m_busy[m] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        st = !m_busy[m] && rd_start && m_full[m][m_rsel[m]] && (rd_len != 0);
        dn = m_busy[m] && (cyc == m_dcyc[m]);
        if (!m_full[m][m_wsel[m]]) begin
          for (int r = 0; r < R; r++)
            if (wr_en[r]) mm[m][m_wsel[m]][r][wr_addr[r]] = wr_data[r];
          if (wr_commit) begin
            m_full[m][m_wsel[m]] = 1'b1;
            m_wsel[m] = !m_wsel[m];
          end
        end
        if (dn) begin
          m_full[m][m_rsel[m]] = 1'b0;
          m_rsel[m] = !m_rsel[m];
          m_busy[m] = 0;
        end
        if (st) begin
          m_busy[m] = 1;
          m_half[m] = m_rsel[m];
          m_t0[m]   = cyc + 1;
          m_len[m]  = (rd_len > DEPTH) ? DEPTH : int'(rd_len);
          m_dcyc[m] = m_t0[m] + 1 + m_len[m] + ((m == 0) ? R - 1 : 0);
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int kk, sk;
    bit v;
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        sk = (m == 0) ? 1 : 0;
        chk("wr_ready", m, o_ready[m], !m_full[m][m_wsel[m]]);
        chk("rd_busy", m, o_busy[m], m_busy[m]);
        chk("full", m, o_full[m], m_full[m]);
        chk("rd_done", m, o_done[m], m_busy[m] && (cyc == m_dcyc[m]));
        for (int r = 0; r < R; r++) begin
          kk = cyc - m_t0[m] - 2 - sk * r;
          v  = m_busy[m] && (kk >= 0) && (kk < m_len[m]);
          chk("rd_valid", m, o_valid[m][r], v);
          chk("rd_data", m, o_data[m][r], v ? int'(mm[m][m_half[m]][r][kk]) : 0);
        end
      end
    end
  end

  // Event recorder for the literal checks.
  int done_cnt [2], done_at [2], start_at [2];
  bit pbusy [2];
  bit pv0;
  int allv_cnt;
  logic [DW-1:0] first0 [$];
  always @(negedge clk) begin
    if (rst) begin
      pbusy[0] = 0; pbusy[1] = 0; pv0 = 0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (o_done[m]) begin done_cnt[m]++; done_at[m] = cyc; end
        if (o_busy[m] && !pbusy[m]) start_at[m] = cyc;
        pbusy[m] = o_busy[m];
      end
      if (o_valid[0][0] && !pv0) first0.push_back(o_data[0][0]);
      pv0 = o_valid[0][0];
      if (o_valid[1] == '1) allv_cnt++;
    end
  end

  int t0, ndone, d1;

  task automatic fill(int n, int base, int mult);
    for (int k = 0; k < n; k++) begin
      wr_en = '1;
      for (int r = 0; r < R; r++) begin
        wr_addr[r] = AW'(k);
        wr_data[r] = DW'(base + r * mult + k);
      end
      @(negedge clk);
    end
    wr_en = '0;
  endtask

  task automatic commit();
    wr_commit = 1; @(negedge clk); wr_commit = 0;
  endtask

  task automatic pulse_start(int len);
    rd_start = 1; rd_len = (AW+1)'(len); t0 = cyc + 1;
    @(negedge clk);
    rd_start = 0;
  endtask

  task automatic wait_dones(int tgt, int budget);
    int n = 0;
    while ((done_cnt[0] < tgt || done_cnt[1] < tgt) && n < budget) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    chk("wait_done", 0, (done_cnt[0] >= tgt) && (done_cnt[1] >= tgt), 1);
  endtask

  initial begin
    rst = 1; wr_en = '0; wr_addr = '0; wr_data = '0;
    wr_commit = 0; rd_start = 0; rd_len = '0; ndone = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("rst_ready", m, o_ready[m], 1);
      chk("rst_full", m, o_full[m], 0);
      chk("rst_busy", m, o_busy[m], 0);
    end

    // Skewed readout of r*16+k, 8 words.
    fill(8, 0, 16); commit();
    pulse_start(8);
    repeat (7) @(negedge clk);
    chk("t2_row2_valid", 0, o_valid[0][2], 1);
    chk("t2_row2_word3", 0, o_data[0][2], 'h23);
    ndone += 1; wait_dones(ndone, 100);
    chk("t2_done_cycle", 0, done_at[0], t0 + 12);
    chk("t2_done_cycle", 1, done_at[1], t0 + 9);
    chk("t2_full_after", 0, o_full[0], 0);

    // Ignored starts: nothing full, zero length, restart while running.
    pulse_start(4);
    @(negedge clk);
    chk("t5_empty_start", 0, o_busy[0], 0);
    fill(6, 'h200, 16); commit();
    pulse_start(0);
    @(negedge clk);
    chk("t5_len0_start", 0, o_busy[0], 0);
    chk("t5_len0_start", 1, o_busy[1], 0);
    pulse_start(6);
    repeat (2) @(negedge clk);
    rd_start = 1; @(negedge clk); rd_start = 0;
    ndone += 1; wait_dones(ndone, 100);
    chk("t5_no_restart", 0, done_at[0], t0 + 10);

    // Ping-pong: refill the other half during the run, start held high.
    fill(4, 'h300, 16); commit();
    rd_start = 1; rd_len = 4; t0 = cyc + 1;
    @(negedge clk);
    fill(4, 'h400, 16); commit();
    chk("t3_ready_low", 0, o_ready[0], 0);
    chk("t3_ready_low", 1, o_ready[1], 0);
    wait_dones(ndone + 1, 100);
    d1 = done_at[0];
    ndone += 2; wait_dones(ndone, 100);
    rd_start = 0;
    chk("t3_b2b_start", 0, start_at[0], d1 + 2);
    chk("t3_half1_word0", 0, first0[first0.size()-1], 'h400);

    // Backpressure: both halves full, the stray write must vanish.
    fill(2, 'h500, 16); commit();
    fill(2, 'h600, 16); commit();
    chk("t4_ready_low", 0, o_ready[0], 0);
    chk("t4_ready_low", 1, o_ready[1], 0);
    wr_en = '1; wr_addr = '0; wr_data = {R{16'hFFFF}};
    @(negedge clk);
    wr_en = '0;
    rd_start = 1; rd_len = 2;
    ndone += 2; wait_dones(ndone, 100);
    rd_start = 0;
    chk("t4_half0_word0", 0, first0[first0.size()-2], 'h500);
    chk("t4_half1_word0", 0, first0[first0.size()-1], 'h600);

    // Full-depth run; all aligned rows valid together.
    fill(256, 'h1000, 256); commit();
    allv_cnt = 0;
    pulse_start(256);
    ndone += 1; wait_dones(ndone, 400);
    chk("t6_all_valid", 1, allv_cnt, 256);
    chk("t6_done_cycle", 1, done_at[1], t0 + 257);
    chk("t6_done_cycle", 0, done_at[0], t0 + 260);

    // Oversized length saturates to DEPTH.
    fill(256, 'h2000, 256); commit();
    pulse_start(300);
    ndone += 1; wait_dones(ndone, 400);
    chk("sat_done_cycle", 0, done_at[0], t0 + 260);

    // Reset in the middle of a 200-word run.
    commit();
    pulse_start(200);
    repeat (50) @(negedge clk);
    chk("pre_rst_busy", 0, o_busy[0], 1);
    #2 rst = 1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_mid_busy", m, o_busy[m], 0);
      chk("rst_mid_valid", m, o_valid[m], 0);
      chk("rst_mid_full", m, o_full[m], 0);
      chk("rst_mid_ready", m, o_ready[m], 1);
      chk("rst_mid_data", m, o_data[m][0], 0);
    end
    @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
